// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core request ports, the arbiter and the shared memory.
// The master side is the environment (core + memory); the arbiter takes the slave side.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_gnt;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
               mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Per-cycle arbiter sharing one single-port synchronous memory between instruction fetch
// and load/store; data wins ties unless fetch has lost STARVE_LIMIT cycles in a row.
module mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 10,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0]         starve_cnt;
    logic                  starved;
    logic                  if_gnt_w;
    logic                  d_gnt_w;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [DATA_WIDTH-1:0] rdata_w;

    assign starved = (starve_cnt == CW'(STARVE_LIMIT));

    always_comb begin
        if_gnt_w = 1'b0;
        d_gnt_w  = 1'b0;
        if (rst_n) begin
            if (bus.d_req && !(bus.if_req && starved)) begin
                d_gnt_w = 1'b1;
            end else if (bus.if_req) begin
                if_gnt_w = 1'b1;
            end
        end
    end

    // Idle cycles still present the fetch address: a harmless read with no rvalid.
    assign addr_sel      = d_gnt_w ? bus.d_addr : bus.if_addr;
    assign rdata_w       = bus.mem_rdata;

    assign bus.if_gnt    = if_gnt_w;
    assign bus.d_gnt     = d_gnt_w;
    assign bus.mem_addr  = addr_sel;
    assign bus.mem_we    = d_gnt_w & bus.d_we;
    assign bus.mem_wdata = bus.d_wdata;
    assign bus.if_rdata  = rdata_w;
    assign bus.d_rdata   = rdata_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.if_rvalid <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            starve_cnt    <= '0;
        end else begin
            bus.if_rvalid <= if_gnt_w;
            bus.d_rvalid  <= d_gnt_w & ~bus.d_we;
            if (!bus.if_req || if_gnt_w) begin
                starve_cnt <= '0;
            end else if (d_gnt_w && !starved) begin
                starve_cnt <= starve_cnt + CW'(1);
            end
        end
    end
endmodule
